// File: rtl/mc14500_fetch_unit_pkg.sv
// Shared types for the MC14500B fetch/sequencer stage: ICU opcodes, sequencer states, program word layout.
// Optional return stack is selected with MC14500_RET_STACK_EN (see mc14500_fetch_unit.sv).
package mc14500_fetch_unit_pkg;

    typedef enum logic [3:0] {
        NOPO = 4'h0,
        LD   = 4'h1,
        LDC  = 4'h2,
        AND  = 4'h3,
        ANDC = 4'h4,
        OR   = 4'h5,
        ORC  = 4'h6,
        XNOR = 4'h7,
        STO  = 4'h8,
        STOC = 4'h9,
        IEN  = 4'hA,
        OEN  = 4'hB,
        JMP  = 4'hC,
        RTN  = 4'hD,
        SKZ  = 4'hE,
        NOPF = 4'hF
    } instruction_t;

    // Plain vector plus constants so state encodings stay visible to legacy tooling.
    typedef logic [2:0] fetch_state_t;
    localparam fetch_state_t S_IDLE    = 3'd0;
    localparam fetch_state_t S_FETCH   = 3'd1;
    localparam fetch_state_t S_ISSUE   = 3'd2;
    localparam fetch_state_t S_RELEASE = 3'd3;
    localparam fetch_state_t S_UPDATE  = 3'd4;

    localparam int PROG_OPERAND_W = 8;

    typedef struct packed {
        instruction_t                opcode;
        logic [PROG_OPERAND_W-1:0]   operand;
    } prog_word_t;

endpackage

// File: rtl/mc14500_fetch_unit_if.sv
// Program-memory and ICU handshake bundle between the fetch unit (master) and ROM/ICU (slave).
// Signal set is identical with or without MC14500_RET_STACK_EN.
interface mc14500_fetch_unit_if
    import mc14500_fetch_unit_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int OPERAND_W = 8
);

    logic [ADDR_W-1:0]      prog_addr;
    logic [4+OPERAND_W-1:0] prog_data;
    instruction_t           instruction;
    logic [OPERAND_W-1:0]   operand;
    logic                   req_next;
    logic                   ack_next;
    logic                   jmp;
    logic                   rtn;

    modport master (
        output prog_addr,
        output instruction,
        output operand,
        output req_next,
        input  prog_data,
        input  ack_next,
        input  jmp,
        input  rtn
    );

    modport slave (
        input  prog_addr,
        input  instruction,
        input  operand,
        input  req_next,
        output prog_data,
        output ack_next,
        output jmp,
        output rtn
    );

endinterface

// File: rtl/mc14500_fetch_unit_return_stack.sv
// LIFO of return addresses for call/return sequencing; only built when MC14500_RET_STACK_EN is defined.
// Push on full and pop on empty are ignored here; the caller flags them.
`ifdef MC14500_RET_STACK_EN
module mc14500_fetch_unit_return_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] sp_q;
    logic [PTR_W-1:0] sp_d;
    logic [IDX_W-1:0] top_idx;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (sp_q == PTR_W'(DEPTH));
    assign empty_o = (sp_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o && !push_i;
    assign top_idx = IDX_W'(sp_q - PTR_W'(1));
    assign top_o   = mem_q[top_idx];

    always_comb begin
        sp_d = sp_q;
        if (do_push) begin
            sp_d = sp_q + PTR_W'(1);
        end else if (do_pop) begin
            sp_d = sp_q - PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sp_q <= sp_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (do_push && (sp_q == PTR_W'(i))) begin
                    mem_q[i] <= push_data_i;
                end
            end
        end
    end

endmodule
`endif

// File: rtl/mc14500_fetch_unit.sv
// MC14500B fetch/sequencer: owns the PC, reads sync program ROM, runs one four-phase req/ack per instruction.
// Define MC14500_RET_STACK_EN for call/return semantics (JMP pushes pc+1, RTN pops); otherwise RTN just advances.
module mc14500_fetch_unit
    import mc14500_fetch_unit_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int OPERAND_W   = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    mc14500_fetch_unit_if.master bus,
    output logic [ADDR_W-1:0]    pc,
    output logic                 busy,
    output logic                 stack_err
);

    if ((OPERAND_W < ADDR_W) || (STACK_DEPTH < 1)) begin : g_param_check
        $error("mc14500_fetch_unit: need OPERAND_W >= ADDR_W and STACK_DEPTH >= 1");
    end

    fetch_state_t          state_q;
    fetch_state_t          state_d;
    logic [ADDR_W-1:0]     pc_q;
    logic [ADDR_W-1:0]     pc_d;
    logic [ADDR_W-1:0]     pc_inc;
    logic [ADDR_W-1:0]     jmp_target;
    instruction_t          instr_q;
    logic [OPERAND_W-1:0]  operand_q;
    logic                  req_q;
    logic                  in_update;

`ifdef MC14500_RET_STACK_EN
    logic                  push_req;
    logic                  pop_req;
    logic                  err_set;
    logic                  err_q;
    logic                  stk_full;
    logic                  stk_empty;
    logic [ADDR_W-1:0]     stk_top;
`endif

    assign pc_inc     = pc_q + ADDR_W'(1);
    assign jmp_target = operand_q[ADDR_W-1:0];
    assign in_update  = (state_q == S_UPDATE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (run)           state_d = S_FETCH;
            S_FETCH:                      state_d = S_ISSUE;
            S_ISSUE:   if (bus.ack_next)  state_d = S_RELEASE;
            S_RELEASE: if (!bus.ack_next) state_d = S_UPDATE;
            S_UPDATE:  state_d = run ? S_FETCH : S_IDLE;
            default:                      state_d = S_IDLE;
        endcase
    end

    // ICU flags are only trusted in S_UPDATE; jmp takes priority over rtn.
    always_comb begin
        pc_d = pc_inc;
`ifdef MC14500_RET_STACK_EN
        push_req = 1'b0;
        pop_req  = 1'b0;
        err_set  = 1'b0;
`endif
        if (bus.jmp) begin
            pc_d = jmp_target;
`ifdef MC14500_RET_STACK_EN
            push_req = 1'b1;
            err_set  = stk_full;
`endif
        end else if (bus.rtn) begin
`ifdef MC14500_RET_STACK_EN
            if (stk_empty) begin
                err_set = 1'b1;
            end else begin
                pc_d    = stk_top;
                pop_req = 1'b1;
            end
`else
            pc_d = pc_inc;
`endif
        end
    end

    // The ROM registers its address, so the next PC is presented during S_UPDATE
    // and the word is ready to latch at the end of S_FETCH.
    assign bus.prog_addr   = in_update ? pc_d : pc_q;
    assign bus.instruction = instr_q;
    assign bus.operand     = operand_q;
    assign bus.req_next    = req_q;
    assign pc              = pc_q;
    assign busy            = (state_q != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            instr_q   <= NOPO;
            operand_q <= '0;
            req_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= (state_d == S_ISSUE);
            if (state_q == S_FETCH) begin
                instr_q   <= instruction_t'(bus.prog_data[OPERAND_W +: 4]);
                operand_q <= bus.prog_data[OPERAND_W-1:0];
            end
            if (in_update) begin
                pc_q <= pc_d;
            end
        end
    end

`ifdef MC14500_RET_STACK_EN
    mc14500_fetch_unit_return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_W)
    ) u_return_stack (
        .clk         (clk),
        .rst         (rst),
        .push_i      (in_update && push_req),
        .pop_i       (in_update && pop_req),
        .push_data_i (pc_inc),
        .top_o       (stk_top),
        .full_o      (stk_full),
        .empty_o     (stk_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (in_update && err_set) begin
            err_q <= 1'b1;
        end
    end

    assign stack_err = err_q;
`else
    assign stack_err = 1'b0;
`endif

endmodule

// File: tb/tb_mc14500_fetch_unit.sv
// Directed bench for mc14500_fetch_unit: sync ROM model, ICU ack model, vector tables per program.
// Extra call/return vectors are compiled in when MC14500_RET_STACK_EN is defined.
module tb_mc14500_fetch_unit;
    import mc14500_fetch_unit_pkg::*;

    typedef struct packed {
        logic [7:0]   pc;
        instruction_t op;
        logic [7:0]   opnd;
        logic         jmp;
        logic         rtn;
        logic [7:0]   next_pc;
        logic         err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       ack_auto;
    logic       ack_man;
    logic       jmp_r;
    logic       rtn_r;
    logic [7:0] pc;
    logic       busy;
    logic       stack_err;

    prog_word_t rom [256];
    vec_t       vecs [16];
    int         nvec;
    int         checks = 0;
    int         errors = 0;

    mc14500_fetch_unit_if #(.ADDR_W(8), .OPERAND_W(8)) bus ();

    mc14500_fetch_unit #(
        .ADDR_W      (8),
        .OPERAND_W   (8),
        .STACK_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .bus       (bus),
        .pc        (pc),
        .busy      (busy),
        .stack_err (stack_err)
    );

    always #5 clk = ~clk;

    // ICU model: ack mirrors req unless the bench takes manual control.
    assign bus.ack_next = ack_auto ? bus.req_next : ack_man;
    assign bus.jmp      = jmp_r;
    assign bus.rtn      = rtn_r;

    always @(posedge clk) bus.prog_data <= rom[bus.prog_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic [7:0] a, input instruction_t op, input logic [7:0] opnd,
                           input logic j, input logic r, input logic [7:0] nxt, input logic e);
        vecs[nvec] = {a, op, opnd, j, r, nxt, e};
        nvec++;
    endtask

    task automatic load_rom();
        for (int i = 0; i < 256; i++) rom[i] = prog_word_t'(12'h000);
        for (int i = 0; i < nvec; i++) rom[vecs[i].pc] = prog_word_t'({vecs[i].op, vecs[i].opnd});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        jmp_r = 1'b0;
        rtn_r = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_req(input int budget, output int waited);
        waited = 0;
        while (bus.req_next !== 1'b1 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
    endtask

    // One instruction: wait for req, check issued word, drive ICU flags, check PC/ROM address in the next fetch.
    task automatic exec_vec(input vec_t v, input int exp_wait);
        int w;
        wait_req(12, w);
        check("req_rise", {31'b0, bus.req_next}, 32'd1);
        check("issue_latency", w, exp_wait);
        check("pc_issued", pc, v.pc);
        check("instruction", bus.instruction, v.op);
        check("operand", bus.operand, v.opnd);
        $display("issue pc=%02h op=%s opnd=%02h jmp=%0b rtn=%0b wait=%0d",
                 pc, bus.instruction.name(), bus.operand, v.jmp, v.rtn, w);
        jmp_r = v.jmp;
        rtn_r = v.rtn;
        repeat (3) @(negedge clk);
        check("next_pc", pc, v.next_pc);
        check("prog_addr", bus.prog_addr, v.next_pc);
        check("req_low", {31'b0, bus.req_next}, 32'd0);
        check("stack_err", {31'b0, stack_err}, {31'b0, v.err});
    endtask

    task automatic run_vecs();
        for (int i = 0; i < nvec; i++) exec_vec(vecs[i], (i == 0) ? 2 : 1);
    endtask

    initial begin
        int w;
        rst      = 1'b1;
        run      = 1'b0;
        ack_auto = 1'b1;
        ack_man  = 1'b0;
        jmp_r    = 1'b0;
        rtn_r    = 1'b0;

        // Main program: sequential LDs, chained jumps, jmp+rtn together, 0xFF wrap.
        nvec = 0;
        add_vec(8'h00, LD,   8'h00, 1'b0, 1'b0, 8'h01, 1'b0);
        add_vec(8'h01, LDC,  8'h11, 1'b0, 1'b0, 8'h02, 1'b0);
        add_vec(8'h02, AND,  8'h22, 1'b0, 1'b0, 8'h03, 1'b0);
        add_vec(8'h03, OR,   8'h33, 1'b0, 1'b0, 8'h04, 1'b0);
        add_vec(8'h04, JMP,  8'h10, 1'b1, 1'b0, 8'h10, 1'b0);
        add_vec(8'h10, JMP,  8'h42, 1'b1, 1'b0, 8'h42, 1'b0);
        add_vec(8'h42, XNOR, 8'h7E, 1'b0, 1'b0, 8'h43, 1'b0);
        add_vec(8'h43, JMP,  8'hFE, 1'b1, 1'b1, 8'hFE, 1'b0);
        add_vec(8'hFE, STO,  8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0);
        add_vec(8'hFF, NOPF, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        add_vec(8'h00, LD,   8'h00, 1'b0, 1'b0, 8'h01, 1'b0);
        load_rom();

        repeat (2) @(negedge clk);
        check("rst_req", {31'b0, bus.req_next}, 32'd0);
        check("rst_pc", pc, 32'h00);
        check("rst_prog_addr", bus.prog_addr, 32'h00);
        check("rst_instruction", bus.instruction, NOPO);
        check("rst_operand", bus.operand, 32'h00);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_stack_err", {31'b0, stack_err}, 32'd0);

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", {31'b0, busy}, 32'd0);
        check("idle_req", {31'b0, bus.req_next}, 32'd0);

        // Slow ICU: req must hold until ack, and PC must not move until ack falls.
        ack_auto = 1'b0;
        run      = 1'b1;
        wait_req(12, w);
        check("slow_latency", w, 2);
        check("slow_pc", pc, 32'h00);
        repeat (3) @(negedge clk);
        check("slow_req_hold", {31'b0, bus.req_next}, 32'd1);
        check("slow_instr_hold", bus.instruction, LD);
        ack_man = 1'b1;
        @(negedge clk);
        check("slow_req_drop", {31'b0, bus.req_next}, 32'd0);
        check("slow_instr_ack", bus.instruction, LD);
        repeat (2) @(negedge clk);
        check("slow_pc_hold", pc, 32'h00);
        check("slow_busy", {31'b0, busy}, 32'd1);
        ack_man = 1'b0;
        repeat (2) @(negedge clk);
        check("slow_pc_next", pc, 32'h01);
        check("slow_prog_addr", bus.prog_addr, 32'h01);
        wait_req(12, w);
        check("slow_req2", {31'b0, bus.req_next}, 32'd1);
        check("slow_instr2", bus.instruction, LDC);

        // Asynchronous reset while req is high in S_ISSUE.
        #1 rst = 1'b1;
        #1;
        check("mid_rst_req", {31'b0, bus.req_next}, 32'd0);
        check("mid_rst_pc", pc, 32'h00);
        check("mid_rst_instruction", bus.instruction, NOPO);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        ack_auto = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_vecs();

        // run falls during a handshake: finish it, update PC, then stay idle.
        jmp_r = 1'b0;
        rtn_r = 1'b0;
        wait_req(12, w);
        check("drop_latency", w, 1);
        check("drop_pc", pc, 32'h01);
        run = 1'b0;
        repeat (3) @(negedge clk);
        check("drop_busy", {31'b0, busy}, 32'd0);
        check("drop_pc_next", pc, 32'h02);
        repeat (3) @(negedge clk);
        check("drop_idle_req", {31'b0, bus.req_next}, 32'd0);
        check("drop_idle_pc", pc, 32'h02);

        // Return handling.
        nvec = 0;
        add_vec(8'h00, JMP, 8'h10, 1'b1, 1'b0, 8'h10, 1'b0);
        add_vec(8'h10, JMP, 8'h42, 1'b1, 1'b0, 8'h42, 1'b0);
`ifdef MC14500_RET_STACK_EN
        add_vec(8'h42, RTN, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0);
        add_vec(8'h11, RTN, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0);
        add_vec(8'h01, RTN, 8'h00, 1'b0, 1'b1, 8'h02, 1'b1);
`else
        add_vec(8'h42, RTN, 8'h00, 1'b0, 1'b1, 8'h43, 1'b0);
        add_vec(8'h43, JMP, 8'h20, 1'b1, 1'b1, 8'h20, 1'b0);
        add_vec(8'h20, RTN, 8'h00, 1'b0, 1'b1, 8'h21, 1'b0);
`endif
        load_rom();
        run = 1'b1;
        do_reset();
        run_vecs();

`ifdef MC14500_RET_STACK_EN
        // Five nested calls into a four-deep stack: fifth push dropped, jump still taken.
        nvec = 0;
        add_vec(8'h00, JMP, 8'h30, 1'b1, 1'b0, 8'h30, 1'b0);
        add_vec(8'h30, JMP, 8'h31, 1'b1, 1'b0, 8'h31, 1'b0);
        add_vec(8'h31, JMP, 8'h32, 1'b1, 1'b0, 8'h32, 1'b0);
        add_vec(8'h32, JMP, 8'h33, 1'b1, 1'b0, 8'h33, 1'b0);
        add_vec(8'h33, JMP, 8'h50, 1'b1, 1'b0, 8'h50, 1'b1);
        add_vec(8'h50, LD,  8'h0F, 1'b0, 1'b0, 8'h51, 1'b1);
        load_rom();
        do_reset();
        run_vecs();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
